// File: rtl/link_upstream_serializer_pkg.sv
// Package for the upstream link serializer.
// Holds the FSM state type, the default widths/credit depth and the
// function that derives the index of the final beat of a word.
// Optional feature macro: LINK_UP_CHECKSUM_EN (adds an XOR checksum beat).
package link_up_pkg;

    localparam int CORE_W_DEF  = 32;
    localparam int IO_W_DEF    = 8;
    localparam int CREDITS_DEF = 16;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Index of the last beat of a word: data beats only, or data beats
    // followed by one checksum beat.
    function automatic int calc_last(input int beats);
`ifdef LINK_UP_CHECKSUM_EN
        return beats;
`else
        return beats - 1;
`endif
    endfunction

endpackage

// File: rtl/link_upstream_serializer_if.sv
// Bus interface of the upstream link serializer.
// Core side: core_valid_i / core_data_i / core_ready_o.
// Link side: io_valid_o / io_data_o, io_token_i (credit return pulse).
// Status:    credit_cnt_o, token_err_o, state_dbg (FSM state for checkers).
// Handshake: a core word transfers on every clk edge where core_valid_i and
// core_ready_o are both high; core_ready_o never depends on core_valid_i.
// The link side has no ready; flow control is purely by word credits.
interface link_upstream_serializer_if
    import link_up_pkg::*;
#(
    parameter int CORE_W  = CORE_W_DEF,
    parameter int IO_W    = IO_W_DEF,
    parameter int CREDITS = CREDITS_DEF
) ();

    localparam int CNT_W = $clog2(CREDITS + 1);

    logic              core_valid_i;
    logic [CORE_W-1:0] core_data_i;
    logic              core_ready_o;
    logic              io_valid_o;
    logic [IO_W-1:0]   io_data_o;
    logic              io_token_i;
    logic [CNT_W-1:0]  credit_cnt_o;
    logic              token_err_o;
    state_e            state_dbg;

    // Environment side (core producer + link consumer).
    modport master (
        output core_valid_i, core_data_i, io_token_i,
        input  core_ready_o, io_valid_o, io_data_o, credit_cnt_o,
               token_err_o, state_dbg
    );

    // Serializer side.
    modport slave (
        input  core_valid_i, core_data_i, io_token_i,
        output core_ready_o, io_valid_o, io_data_o, credit_cnt_o,
               token_err_o, state_dbg
    );

endinterface

// File: rtl/link_upstream_serializer_credit_cnt.sv
// Saturating word-credit counter for the upstream link serializer.
// Ports: clk, rst_n (async, active-low), inc_i (token returned),
//        dec_i (word accepted), cnt_o (current credits),
//        nonzero_o (credits > 0), err_o (sticky: token while full).
module link_up_credit_cnt #(
    parameter int CREDITS = 16,
    parameter int CNT_W   = $clog2(CREDITS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             nonzero_o,
    output logic             err_o
);

    localparam logic [CNT_W-1:0] MAX = CNT_W'(CREDITS);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= MAX;
            err_q <= 1'b0;
        end else begin
            case ({inc_i, dec_i})
                2'b10: begin
                    // A token while already full means the receiver returned
                    // more credits than it was ever given.
                    if (cnt_q == MAX) err_q <= 1'b1;
                    else              cnt_q <= cnt_q + 1'b1;
                end
                2'b01: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                end
                default: ;  // none, or token and accept cancel out
            endcase
        end
    end

    assign cnt_o     = cnt_q;
    assign nonzero_o = (cnt_q != '0);
    assign err_o     = err_q;

endmodule

// File: rtl/link_upstream_serializer.sv
// Upstream link serializer: splits CORE_W-bit core words into IO_W-bit link
// bytes, least-significant byte first, one byte per cycle, gated by word
// credits returned through io_token_i.
// Ports: clk, rst_n (async, active-low), bus (link_upstream_serializer_if.slave).
// Optional feature macro: LINK_UP_CHECKSUM_EN appends one beat carrying the
// XOR of all data bytes of the word.
module link_upstream_serializer
    import link_up_pkg::*;
#(
    parameter int CORE_W  = CORE_W_DEF,
    parameter int IO_W    = IO_W_DEF,
    parameter int CREDITS = CREDITS_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    link_upstream_serializer_if.slave     bus
);

    localparam int BEATS  = CORE_W / IO_W;
    localparam int LAST   = calc_last(BEATS);
    localparam int SREG_W = (LAST + 1) * IO_W;
    localparam int BW     = (LAST > 0) ? $clog2(LAST + 1) : 1;
    localparam int CNT_W  = $clog2(CREDITS + 1);
    localparam logic [BW-1:0] LAST_B = BW'(LAST);

    state_e              state_q, state_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic [SREG_W-1:0]   sreg_q, sreg_d;
    logic                io_valid_q, io_valid_d;
    logic [IO_W-1:0]     io_data_q, io_data_d;
    logic [SREG_W-1:0]   frame;
    logic                core_ready;
    logic                accept;
    logic                credit_ok;
    logic [CNT_W-1:0]    credit_cnt;
    logic                token_err;

`ifdef LINK_UP_CHECKSUM_EN
    logic [IO_W-1:0] cksum;

    always_comb begin
        cksum = '0;
        for (int i = 0; i < BEATS; i++) begin
            cksum = cksum ^ bus.core_data_i[i*IO_W +: IO_W];
        end
    end

    // The checksum rides in the top byte so the shifter emits it last.
    assign frame = {cksum, bus.core_data_i};
`else
    assign frame = bus.core_data_i;
`endif

    // Byte 0 of an accepted word is registered straight onto the link at the
    // accept edge; sreg_q holds only the bytes still to be sent.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        sreg_d     = sreg_q;
        io_valid_d = 1'b0;
        io_data_d  = '0;
        core_ready = ((state_q == IDLE) || (beat_q == LAST_B)) && credit_ok;
        accept     = bus.core_valid_i && core_ready;

        if (accept) begin
            state_d    = SEND;
            beat_d     = '0;
            io_valid_d = 1'b1;
            io_data_d  = frame[IO_W-1:0];
            sreg_d     = frame >> IO_W;
        end else if (state_q == SEND) begin
            if (beat_q == LAST_B) begin
                state_d = IDLE;
                beat_d  = '0;
                sreg_d  = '0;
            end else begin
                beat_d     = beat_q + 1'b1;
                io_valid_d = 1'b1;
                io_data_d  = sreg_q[IO_W-1:0];
                sreg_d     = sreg_q >> IO_W;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            sreg_q     <= '0;
            io_valid_q <= 1'b0;
            io_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            sreg_q     <= sreg_d;
            io_valid_q <= io_valid_d;
            io_data_q  <= io_data_d;
        end
    end

    link_up_credit_cnt #(
        .CREDITS (CREDITS),
        .CNT_W   (CNT_W)
    ) u_credit (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_i     (bus.io_token_i),
        .dec_i     (accept),
        .cnt_o     (credit_cnt),
        .nonzero_o (credit_ok),
        .err_o     (token_err)
    );

    assign bus.core_ready_o = core_ready;
    assign bus.io_valid_o   = io_valid_q;
    assign bus.io_data_o    = io_data_q;
    assign bus.credit_cnt_o = credit_cnt;
    assign bus.token_err_o  = token_err;
    assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_link_upstream_serializer.sv
// Testbench for link_upstream_serializer.
// The reference model treats the link as a byte queue: an accepted word
// appends its bytes (plus XOR byte when LINK_UP_CHECKSUM_EN), one byte leaves
// per cycle, a new word is taken only when no byte is left waiting behind
// the one on the wire and a credit is available.
module tb_link_upstream_serializer;
    import link_up_pkg::*;

    localparam int CORE_W  = 32;
    localparam int IO_W    = 8;
    localparam int CREDITS = 16;
    localparam int BEATS   = CORE_W / IO_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    link_upstream_serializer_if #(
        .CORE_W (CORE_W), .IO_W (IO_W), .CREDITS (CREDITS)
    ) bus ();

    link_upstream_serializer #(
        .CORE_W (CORE_W), .IO_W (IO_W), .CREDITS (CREDITS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // ---------------- scoreboard state ----------------
    logic [IO_W-1:0] exp_q[$];
    int cred_m;
    logic err_m;
    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [IO_W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("io_valid", {31'd0, bus.io_valid_o}, 32'd1);
            chk("io_data", {24'd0, bus.io_data_o}, {24'd0, e});
        end else begin
            chk("io_valid_idle", {31'd0, bus.io_valid_o}, 32'd0);
        end
    end

    // ---------------- driver + model ----------------
    // Called at negedge+2; returns at the next negedge+2.
    task automatic cycle(input logic v, input logic [CORE_W-1:0] d, input logic tok);
        logic rdy_m, acc;
        logic [IO_W-1:0] b, x;
        bus.core_valid_i = v;
        bus.core_data_i  = d;
        bus.io_token_i   = tok;
        rdy_m = (cred_m != 0) && (exp_q.size() == 0);
        #1;
        chk("core_ready", {31'd0, bus.core_ready_o}, {31'd0, rdy_m});
        chk("credit_cnt", 32'(bus.credit_cnt_o), 32'(cred_m));
        chk("token_err", {31'd0, bus.token_err_o}, {31'd0, err_m});
        @(posedge clk);
        acc = v && rdy_m;
        if (acc) begin
            x = '0;
            for (int i = 0; i < BEATS; i++) begin
                b = d[i*IO_W +: IO_W];
                exp_q.push_back(b);
                x = x ^ b;
            end
`ifdef LINK_UP_CHECKSUM_EN
            exp_q.push_back(x);
`endif
        end
        if (tok && !acc) begin
            if (cred_m == CREDITS) err_m = 1'b1;
            else                   cred_m++;
        end else if (acc && !tok) begin
            cred_m--;
        end
        @(negedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0);
    endtask

    // Asserts reset at negedge+2 and checks outputs clear without a clock.
    task automatic apply_reset();
        rst_n = 1'b0;
        bus.core_valid_i = 1'b0;
        bus.io_token_i   = 1'b0;
        #1;
        chk("rst_io_valid", {31'd0, bus.io_valid_o}, 32'd0);
        chk("rst_io_data", {24'd0, bus.io_data_o}, 32'd0);
        chk("rst_credit", 32'(bus.credit_cnt_o), CREDITS);
        chk("rst_token_err", {31'd0, bus.token_err_o}, 32'd0);
        exp_q.delete();
        cred_m = CREDITS;
        err_m  = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.core_valid_i = 1'b0;
        bus.core_data_i  = '0;
        bus.io_token_i   = 1'b0;
        cred_m = CREDITS;
        err_m  = 1'b0;
        @(negedge clk);
        #2;
        apply_reset();

        // Single word, then let it drain.
        cycle(1'b1, 32'h44332211, 1'b0);
        idle(7);

        // Offer words continuously without tokens until credits run out.
        apply_reset();
        for (int i = 0; i < 70; i++) cycle(1'b1, $urandom, 1'b0);
        // One token at zero credits: the pending word goes next cycle.
        cycle(1'b1, 32'hA5A5_0F0F, 1'b1);
        cycle(1'b1, 32'hDEAD_BEEF, 1'b0);
        idle(6);

        // Bring credits to 5, then token and accept on the same edge.
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);
        cycle(1'b1, 32'h1234_5678, 1'b1);
        idle(6);

        // Refill to full, then one token too many sets the sticky error.
        for (int i = 0; i < 11; i++) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        idle(3);

        // Reset while beat 2 of a word is on the wire.
        apply_reset();
        cycle(1'b1, 32'hCAFE_F00D, 1'b0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        apply_reset();
        idle(6);

        // Random traffic and tokens.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) == 0));
        end
        idle(8);
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
